pc_fetch_sequencer: RTL

- Owns the program counter and sequences instruction fetch over a req/ack handshake to instruction memory.
- Steers the shared 16-bit PC-plus-immediate adder to form branch targets.
- Applies redirects (jump or taken branch) and discards in-flight fetches that a redirect makes stale.
- Sits between instruction memory and the decode stage.

---
 rtl/pc_fetch_sequencer_if.sv | 44 ++++
 rtl/pc_fetch_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch sequencer bus: decode-side controls, shared adder, imem handshake, decode outputs.
// Latency: none, pure wiring bundle.
// Backpressure: stall and imem_ack travel here; the modports fix who drives what.
interface pc_fetch_sequencer_if;
    // decode-side control
    logic        stall;
    logic        jump;
    logic [15:0] jump_target;
    logic        branch_taken;
    logic [15:0] branch_offset;

    // shared PC-plus-immediate adder
    logic [15:0] adder_a;
    logic [15:0] adder_b;
    logic [15:0] adder_sum;

    // instruction memory handshake
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;

    // to decode
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        flush;

    // the sequencer side
    modport master (
        input  stall, jump, jump_target, branch_taken, branch_offset,
        input  adder_sum, imem_ack, imem_data,
        output adder_a, adder_b, imem_req, imem_addr,
        output instr_valid, instr, instr_pc, flush
    );

    // memory / decode / adder environment side
    modport slave (
        output stall, jump, jump_target, branch_taken, branch_offset,
        output adder_sum, imem_ack, imem_data,
        input  adder_a, adder_b, imem_req, imem_addr,
        input  instr_valid, instr, instr_pc, flush
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner: sequences imem fetches, applies jump/branch redirects, drops stale fetches.
// Latency: instruction presented one cycle after imem_req && imem_ack; flush one cycle after a redirect.
// Backpressure: stall only blocks launching a request; an issued request holds req/addr until ack.
module pc_fetch_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic                    clk,
    input  logic                    reset,
    pc_fetch_sequencer_if.master    bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] stale_q, stale_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        flush_q, flush_d;

    logic        req;
    logic        xfer;
    logic        redirect;
    logic [15:0] target;

    // Request qualifier: reset kills an outstanding request in the same cycle so a late ack is ignored.
    always_comb begin
        req = 1'b0;
        case (state_q)
            FETCH:       req = !bus.stall;
            WAIT, DRAIN: req = 1'b1;
            default:     req = 1'b0;
        endcase
        if (reset) begin
            req = 1'b0;
        end
    end

    assign xfer     = req && bus.imem_ack;
    assign redirect = (state_q != BOOT) && (bus.jump || bus.branch_taken);
    // jump outranks branch; branch target comes from the shared adder (instr_pc + offset)
    assign target   = bus.jump ? bus.jump_target : bus.adder_sum;

    // Next-state and datapath updates for the fetch FSM.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        stale_d       = stale_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = 1'b0;
        flush_d       = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH, WAIT: begin
                if (redirect) begin
                    // any word acked this cycle is stale; an unacked request must still be drained
                    pc_d    = target;
                    flush_d = 1'b1;
                    if (req && !bus.imem_ack) begin
                        state_d = DRAIN;
                        stale_d = pc_q;
                    end else begin
                        state_d = FETCH;
                    end
                end else if (xfer) begin
                    instr_valid_d = 1'b1;
                    instr_d       = bus.imem_data;
                    instr_pc_d    = pc_q;
                    pc_d          = pc_q + 16'd1;
                    state_d       = FETCH;
                end else if (req) begin
                    state_d = WAIT;
                end else begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                // old address stays on the bus; a new redirect only retargets pc
                if (redirect) begin
                    pc_d    = target;
                    flush_d = 1'b1;
                end
                if (bus.imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            stale_q       <= RESET_VECTOR;
            instr_q       <= 16'h0000;
            instr_pc_q    <= 16'h0000;
            instr_valid_q <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            stale_q       <= stale_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            flush_q       <= flush_d;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = (state_q == DRAIN) ? stale_q : pc_q;
    assign bus.adder_a     = instr_pc_q;
    assign bus.adder_b     = bus.branch_offset;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.flush       = flush_q;

endmodule
